gray_ptr_receiver: RTL and testbench

GRAY_PTR_RECEIVER -- requirements
Module: gray_ptr_receiver

---
 rtl/gray_ptr_receiver.sv | 106 ++++++++++
 tb/tb_gray_ptr_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_receiver.sv
// Read-side pointer logic for an asynchronous FIFO. It brings the producer's
// gray-coded write pointer into the clk domain through a synchronizer chain,
// decodes it to binary, and tracks the local read pointer. It also reports
// occupancy and three sticky error flags: an illegal gray jump, a read while
// empty, and occupancy beyond the FIFO depth.
module gray_ptr_receiver #(
  parameter int SIZE        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE:0]   wgray_async,
  input  logic            rd_en,
  output logic [SIZE-1:0] rd_addr,
  output logic [SIZE:0]   rd_gray,
  output logic [SIZE:0]   wbin_sync,
  output logic [SIZE:0]   count,
  output logic            empty,
  output logic            gray_err,
  output logic            underflow,
  output logic            ovf_err
);

  localparam logic [SIZE:0] PTR_ONE   = {{SIZE{1'b0}}, 1'b1};
  localparam logic [SIZE:0] PTR_DEPTH = {1'b1, {SIZE{1'b0}}};

  // Stage 0 is the metastability-exposed capture flop; the last stage is wgray_s.
  logic [SYNC_STAGES-1:0][SIZE:0] sync_q;
  logic [SIZE:0]                  wgray_s;
  logic [SIZE:0]                  wgray_prev;
  logic [SIZE:0]                  gray_diff;
  logic                           gray_jump;
  logic [SIZE:0]                  rbin;
  logic [SIZE:0]                  rbin_next;
  logic                           rd_ok;

  function automatic logic [SIZE:0] gray2bin(input logic [SIZE:0] g);
    logic [SIZE:0] b;
    b[SIZE] = g[SIZE];
    for (int i = SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wgray_s = sync_q[SYNC_STAGES-1];

  // A legal gray pointer moves one bit at a time. A nonzero difference with
  // more than one bit set survives clearing its lowest set bit.
  assign gray_diff = wgray_s ^ wgray_prev;
  assign gray_jump = |(gray_diff & (gray_diff - PTR_ONE));

  // Occupancy is derived purely from registered pointers.
  assign count   = wbin_sync - rbin;
  assign empty   = (wbin_sync == rbin);
  assign rd_addr = rbin[SIZE-1:0];

  // A read is accepted only against the current empty flag.
  assign rd_ok     = rd_en & ~empty;
  assign rbin_next = rd_ok ? (rbin + PTR_ONE) : rbin;

  // Plain shift chain with no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wgray_async};
    end
  end

  // Decode the synchronized pointer and remember the last sample for the jump check.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_sync  <= '0;
      wgray_prev <= '0;
    end else begin
      wbin_sync  <= gray2bin(wgray_s);
      wgray_prev <= wgray_s;
    end
  end

  // Read pointer and its gray image advance together so rd_gray is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbin    <= '0;
      rd_gray <= '0;
    end else begin
      rbin    <= rbin_next;
      rd_gray <= (rbin_next >> 1) ^ rbin_next;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err  <= 1'b0;
      underflow <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      gray_err  <= gray_err | gray_jump;
      underflow <= underflow | (rd_en & empty);
      ovf_err   <= ovf_err | (count > PTR_DEPTH);
    end
  end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver (SIZE=4, SYNC_STAGES=2): directed scenarios
// checked against hand-derived constants, then random traffic checked against
// an integer pointer model.
module tb_gray_ptr_receiver;
  localparam int SIZE        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int W           = SIZE + 1;
  localparam int MOD         = 1 << W;
  localparam int DEPTH       = 1 << SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  wgray_async;
  logic          rd_en;
  logic [SIZE-1:0] rd_addr;
  logic [W-1:0]  rd_gray;
  logic [W-1:0]  wbin_sync;
  logic [W-1:0]  count;
  logic          empty;
  logic          gray_err;
  logic          underflow;
  logic          ovf_err;
  logic [22:0]   dut_vec;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers and a delay queue.
  int m_pipe[$];
  int m_prev;
  int m_w;
  int m_r;
  bit m_gerr;
  bit m_under;
  bit m_ovf;

  gray_ptr_receiver #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .wgray_async(wgray_async),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_gray    (rd_gray),
    .wbin_sync  (wbin_sync),
    .count      (count),
    .empty      (empty),
    .gray_err   (gray_err),
    .underflow  (underflow),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  assign dut_vec = {wbin_sync, rd_addr, rd_gray, count, empty, gray_err, underflow, ovf_err};

  function automatic int g2b(int g);
    int b = g;
    for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic int b2g(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int mcount();
    return ((m_w - m_r) % MOD + MOD) % MOD;
  endfunction

  function automatic logic [22:0] model_vec();
    int c = mcount();
    return {W'(m_w), SIZE'(m_r % DEPTH), W'(b2g(m_r)), W'(c), 1'(c == 0), m_gerr, m_under, m_ovf};
  endfunction

  task automatic model_edge(input bit r, input int wg, input bit rd);
    int cnt;
    int ws;
    if (r) begin
      m_pipe = {};
      repeat (SYNC_STAGES) m_pipe.push_back(0);
      m_prev = 0; m_w = 0; m_r = 0;
      m_gerr = 0; m_under = 0; m_ovf = 0;
    end else begin
      cnt = mcount();
      ws  = m_pipe[SYNC_STAGES-1];
      if ($countones(ws ^ m_prev) > 1) m_gerr = 1;
      if (cnt > DEPTH) m_ovf = 1;
      if (rd) begin
        if (cnt == 0) m_under = 1;
        else m_r = (m_r + 1) % MOD;
      end
      m_w    = g2b(ws);
      m_prev = ws;
      m_pipe.push_front(wg);
      void'(m_pipe.pop_back());
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, settle at negedge.
  task automatic tick(input bit r, input logic [W-1:0] wg, input bit rd);
    rst         = r;
    wgray_async = wg;
    rd_en       = rd;
    @(posedge clk);
    model_edge(r, int'(wg), rd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 5'b10101, 1'b1);
    tick(1'b1, 5'b10101, 1'b1);
    checks++; if (wbin_sync !== 5'd0) begin errors++; $display("FAIL reset_wbin wbin_sync=%0d expected 0", wbin_sync); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count count=%0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty empty=%b expected 1", empty); end
    checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL reset_rd_addr rd_addr=%0d expected 0", rd_addr); end
    checks++; if (rd_gray !== 5'd0) begin errors++; $display("FAIL reset_rd_gray rd_gray=%b expected 00000", rd_gray); end
    checks++; if ({gray_err, underflow, ovf_err} !== 3'b000) begin errors++; $display("FAIL reset_flags flags=%b expected 000", {gray_err, underflow, ovf_err}); end
    tick(1'b1, 5'b00000, 1'b0);
  endtask

  task automatic test_latency();
    tick(1'b1, 5'd0, 1'b0);
    tick(1'b0, 5'd0, 1'b0);
    tick(1'b0, 5'd0, 1'b0);
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (wbin_sync !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL latency_k wbin_sync=%0d empty=%b expected 0/1", wbin_sync, empty); end
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (wbin_sync !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL latency_k1 wbin_sync=%0d empty=%b expected 0/1", wbin_sync, empty); end
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (wbin_sync !== 5'd1 || count !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL latency_k2 wbin_sync=%0d count=%0d empty=%b expected 1/1/0", wbin_sync, count, empty);
    end
  endtask

  task automatic test_drain_underflow();
    tick(1'b1, 5'd0, 1'b0);
    for (int b = 1; b <= 5; b++) tick(1'b0, W'(b2g(b)), 1'b0);
    tick(1'b0, 5'b00111, 1'b0);
    tick(1'b0, 5'b00111, 1'b0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL drain_fill count=%0d expected 5", count); end
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        checks++; if (rd_addr !== 4'(i)) begin errors++; $display("FAIL drain_rd_addr rd_addr=%0d expected %0d", rd_addr, i); end
      end else begin
        checks++; if (underflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL drain_pre6 underflow=%b empty=%b expected 0/1", underflow, empty); end
      end
      tick(1'b0, 5'b00111, 1'b1);
    end
    checks++; if (rd_gray !== 5'b00111) begin errors++; $display("FAIL drain_rd_gray rd_gray=%b expected 00111", rd_gray); end
    checks++; if (rd_addr !== 4'd5) begin errors++; $display("FAIL drain_hold rd_addr=%0d expected 5", rd_addr); end
    checks++; if (empty !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow empty=%b underflow=%b expected 1/1", empty, underflow); end
  endtask

  task automatic test_wrap();
    tick(1'b1, 5'd0, 1'b0);
    for (int b = 1; b <= 30; b++) tick(1'b0, W'(b2g(b)), mcount() > 0);
    for (int i = 0; i < 10; i++) tick(1'b0, W'(b2g(30)), mcount() > 0);
    checks++; if (rd_addr !== 4'd14 || rd_gray !== 5'b10001 || count !== 5'd0) begin
      errors++; $display("FAIL wrap_start rd_addr=%0d rd_gray=%b count=%0d expected 14/10001/0", rd_addr, rd_gray, count);
    end
    tick(1'b0, 5'b10000, 1'b0);
    tick(1'b0, 5'b00000, 1'b0);
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL wrap_count1 count=%0d expected 1", count); end
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL wrap_count2 count=%0d expected 2", count); end
    tick(1'b0, 5'b00001, 1'b0);
    checks++; if (count !== 5'd3 || wbin_sync !== 5'd1) begin errors++; $display("FAIL wrap_count3 count=%0d wbin_sync=%0d expected 3/1", count, wbin_sync); end
    checks++; if (gray_err !== 1'b0) begin errors++; $display("FAIL wrap_gray_err gray_err=%b expected 0", gray_err); end
  endtask

  task automatic test_corruption();
    tick(1'b1, 5'd0, 1'b0);
    tick(1'b0, 5'b00011, 1'b0);
    tick(1'b0, 5'b00011, 1'b0);
    checks++; if (gray_err !== 1'b0) begin errors++; $display("FAIL corrupt_early gray_err=%b expected 0", gray_err); end
    tick(1'b0, 5'b00011, 1'b0);
    checks++; if (gray_err !== 1'b1) begin errors++; $display("FAIL corrupt_set gray_err=%b expected 1", gray_err); end
    for (int i = 0; i < 4; i++) tick(1'b0, 5'b00010, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 5'b00110, 1'b0);
    checks++; if (gray_err !== 1'b1) begin errors++; $display("FAIL corrupt_sticky gray_err=%b expected 1", gray_err); end
    tick(1'b1, 5'b00110, 1'b0);
    checks++; if (gray_err !== 1'b0) begin errors++; $display("FAIL corrupt_clear gray_err=%b expected 0", gray_err); end
  endtask

  task automatic test_overflow();
    tick(1'b1, 5'd0, 1'b0);
    for (int b = 1; b <= 17; b++) tick(1'b0, W'(b2g(b)), 1'b0);
    tick(1'b0, W'(b2g(17)), 1'b0);
    checks++; if (count !== 5'd16 || ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_16 count=%0d ovf_err=%b expected 16/0", count, ovf_err); end
    tick(1'b0, W'(b2g(17)), 1'b0);
    checks++; if (count !== 5'd17 || ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_17 count=%0d ovf_err=%b expected 17/0", count, ovf_err); end
    tick(1'b0, W'(b2g(17)), 1'b0);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set ovf_err=%b expected 1", ovf_err); end
  endtask

  task automatic test_random();
    int wb = 0;
    logic [W-1:0] wg;
    bit r;
    tick(1'b1, 5'd0, 1'b0);
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 79) == 0);
      if (r) wb = 0;
      else if ($urandom_range(0, 2) == 0) wb = (wb + 1) % MOD;
      wg = W'(b2g(wb));
      if (!r && $urandom_range(0, 299) == 0) wg = W'($urandom);
      tick(r, wg, 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d {wbin,addr,gray,count,empty,gerr,under,ovf}=%h expected %h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wgray_async = '0;
    rd_en = 1'b0;
    model_edge(1'b1, 0, 1'b0);
    test_reset();
    test_latency();
    test_drain_underflow();
    test_wrap();
    test_corruption();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
